// File: rtl/pcie_us_dma_wr_desc_arb_pkg.sv
// Shared definitions for the DMA write-descriptor arbiter.
//   status_kind_e   : classification of an incoming DMA completion
//   port_idx_width  : width of the port-index field packed into tag MSBs
package pcie_us_dma_wr_desc_arb_pkg;

    typedef enum logic [1:0] {
        STATUS_IDLE,
        STATUS_OK,
        STATUS_UNDERFLOW,
        STATUS_BAD_PORT
    } status_kind_e;

    function automatic int unsigned port_idx_width(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/pcie_us_dma_wr_desc_arb_if.sv
// Descriptor + status bundle. LANES=PORTS on the requester side (flattened
// per-port vectors, one-hot status strobe), LANES=1 toward the DMA engine.
//   desc_*        : descriptor fields/valid, driven by master
//   desc_ready    : descriptor accept, driven by slave
//   status_tag    : completion tag, driven by slave
//   status_valid  : completion strobe per lane, driven by slave
interface pcie_us_dma_wr_desc_arb_if #(
    parameter int LANES           = 1,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8
);
    logic [LANES*PCIE_ADDR_WIDTH-1:0] desc_pcie_addr;
    logic [LANES*AXI_ADDR_WIDTH-1:0]  desc_axi_addr;
    logic [LANES*LEN_WIDTH-1:0]       desc_len;
    logic [LANES*TAG_WIDTH-1:0]       desc_tag;
    logic [LANES-1:0]                 desc_valid;
    logic [LANES-1:0]                 desc_ready;
    logic [TAG_WIDTH-1:0]             status_tag;
    logic [LANES-1:0]                 status_valid;

    modport master (
        output desc_pcie_addr, desc_axi_addr, desc_len, desc_tag, desc_valid,
        input  desc_ready, status_tag, status_valid
    );

    modport slave (
        input  desc_pcie_addr, desc_axi_addr, desc_len, desc_tag, desc_valid,
        output desc_ready, status_tag, status_valid
    );
endinterface

// File: rtl/pcie_us_dma_wr_desc_arb_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins,
// wrapping to the bottom. Pointer moves past the winner only when the grant
// is actually taken (advance).
//   clk, rst      : clock, synchronous active-high reset
//   request       : per-port request mask
//   advance       : grant consumed this cycle
//   grant_onehot  : one-hot winner
//   grant_valid   : some port won
//   grant_index   : encoded winner
module pcie_dma_rr_arbiter #(
    parameter int PORTS       = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       request,
    input  logic                   advance,
    output logic [PORTS-1:0]       grant_onehot,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index
);
    logic [INDEX_WIDTH-1:0] ptr;

    // Two ascending passes: first over indices >= ptr, then the wrapped
    // remainder; the first hit stops further selection.
    always_comb begin
        grant_onehot = '0;
        grant_valid  = 1'b0;
        grant_index  = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (!grant_valid && request[i] && (i >= 32'(ptr))) begin
                grant_valid     = 1'b1;
                grant_onehot[i] = 1'b1;
                grant_index     = INDEX_WIDTH'(i);
            end
        end
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (!grant_valid && request[i]) begin
                grant_valid     = 1'b1;
                grant_onehot[i] = 1'b1;
                grant_index     = INDEX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (grant_index == INDEX_WIDTH'(PORTS - 1)) ? '0 : grant_index + 1'b1;
        end
    end
endmodule

// File: rtl/pcie_us_dma_wr_desc_arb.sv
// Shares one DMA write descriptor/status channel between PORTS requesters.
// Round-robin grant into a single holding register; port index is packed into
// the tag MSBs and used to route completions back. Per-port credit counters
// bound the number of in-flight descriptors.
//   clk, rst      : clock, synchronous active-high reset
//   s_if          : requester side (slave), LANES=PORTS, tag S_TAG_WIDTH
//   m_if          : DMA engine side (master), LANES=1, tag M_TAG_WIDTH
//   enable        : permit new grants
//   status_error  : 1-cycle pulse, completion for idle or nonexistent port
module pcie_us_dma_wr_desc_arb
    import pcie_us_dma_wr_desc_arb_pkg::*;
#(
    parameter int PORTS           = 4,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH       = 20,
    parameter int S_TAG_WIDTH     = 8,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    pcie_us_dma_wr_desc_arb_if.slave       s_if,
    pcie_us_dma_wr_desc_arb_if.master      m_if,
    input  logic                           enable,
    output logic                           status_error
);
    localparam int CL_PORTS  = port_idx_width(PORTS);
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [CNT_WIDTH-1:0]       count [PORTS];
    logic [PORTS-1:0]           eligible;
    logic [PORTS-1:0]           grant_onehot;
    logic                       grant_valid;
    logic [CL_PORTS-1:0]        grant_index;
    logic                       can_load;
    logic                       accept;

    logic [PCIE_ADDR_WIDTH-1:0] sel_pcie_addr;
    logic [AXI_ADDR_WIDTH-1:0]  sel_axi_addr;
    logic [LEN_WIDTH-1:0]       sel_len;
    logic [S_TAG_WIDTH-1:0]     sel_tag;

    logic [PCIE_ADDR_WIDTH-1:0] hold_pcie_addr;
    logic [AXI_ADDR_WIDTH-1:0]  hold_axi_addr;
    logic [LEN_WIDTH-1:0]       hold_len;
    logic [M_TAG_WIDTH-1:0]     hold_tag;
    logic                       hold_valid;

    logic [CL_PORTS-1:0]        status_idx;
    logic [PORTS-1:0]           status_hit;
    logic                       status_underflow;
    status_kind_e               status_kind;
    logic [PORTS-1:0]           port_inc;
    logic [PORTS-1:0]           port_dec;

    logic [PORTS-1:0]           status_valid_reg;
    logic [S_TAG_WIDTH-1:0]     status_tag_reg;

    // ---------------- arbitration ----------------
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            eligible[i] = s_if.desc_valid[i] && (count[i] < CNT_MAX) && enable;
        end
    end

    pcie_dma_rr_arbiter #(
        .PORTS       (PORTS),
        .INDEX_WIDTH (CL_PORTS)
    ) u_rr (
        .clk          (clk),
        .rst          (rst),
        .request      (eligible),
        .advance      (accept),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .grant_index  (grant_index)
    );

    assign can_load        = !hold_valid || m_if.desc_ready[0];
    // rst gating keeps s_ready low while reset is held
    assign accept          = grant_valid && can_load && !rst;
    assign s_if.desc_ready = accept ? grant_onehot : '0;

    always_comb begin
        sel_pcie_addr = '0;
        sel_axi_addr  = '0;
        sel_len       = '0;
        sel_tag       = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (grant_onehot[i]) begin
                sel_pcie_addr |= s_if.desc_pcie_addr[i*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
                sel_axi_addr  |= s_if.desc_axi_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                sel_len       |= s_if.desc_len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_tag       |= s_if.desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
            end
        end
    end

    // ---------------- holding register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid     <= 1'b0;
            hold_pcie_addr <= '0;
            hold_axi_addr  <= '0;
            hold_len       <= '0;
            hold_tag       <= '0;
        end else if (accept) begin
            hold_valid     <= 1'b1;
            hold_pcie_addr <= sel_pcie_addr;
            hold_axi_addr  <= sel_axi_addr;
            hold_len       <= sel_len;
            hold_tag       <= M_TAG_WIDTH'({grant_index, sel_tag});
        end else if (m_if.desc_ready[0]) begin
            hold_valid     <= 1'b0;
        end
    end

    assign m_if.desc_pcie_addr = hold_pcie_addr;
    assign m_if.desc_axi_addr  = hold_axi_addr;
    assign m_if.desc_len       = hold_len;
    assign m_if.desc_tag       = hold_tag;
    assign m_if.desc_valid[0]  = hold_valid;

    // ---------------- status decode and credits ----------------
    assign status_idx = m_if.status_tag[M_TAG_WIDTH-1 -: CL_PORTS];

    // An index with no matching port leaves status_hit empty, which is how
    // out-of-range completions get dropped.
    always_comb begin
        status_hit       = '0;
        port_inc         = '0;
        port_dec         = '0;
        status_underflow = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            status_hit[i] = m_if.status_valid[0] && (status_idx == CL_PORTS'(i));
            port_inc[i]   = accept && grant_onehot[i];
            port_dec[i]   = status_hit[i] && (count[i] != '0);
            if (status_hit[i] && (count[i] == '0)) begin
                status_underflow = 1'b1;
            end
        end
        if (!m_if.status_valid[0]) begin
            status_kind = STATUS_IDLE;
        end else if (status_hit == '0) begin
            status_kind = STATUS_BAD_PORT;
        end else if (status_underflow) begin
            status_kind = STATUS_UNDERFLOW;
        end else begin
            status_kind = STATUS_OK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                case ({port_inc[i], port_dec[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_valid_reg <= '0;
            status_tag_reg   <= '0;
            status_error     <= 1'b0;
        end else begin
            status_valid_reg <= status_hit;
            status_tag_reg   <= m_if.status_tag[S_TAG_WIDTH-1:0];
            status_error     <= (status_kind == STATUS_UNDERFLOW) ||
                                (status_kind == STATUS_BAD_PORT);
        end
    end

    assign s_if.status_valid = status_valid_reg;
    assign s_if.status_tag   = status_tag_reg;
endmodule
